// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard.
// Decode reserves a destination at issue; writeback clears it when the result lands.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic                rsv_ready_o
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic wr_zero, rsv_zero;
  logic wr_ok, rsv_ok;

  assign wr_zero  = ZERO_REG && (wr_addr_i == '0);
  assign rsv_zero = ZERO_REG && (rsv_addr_i == '0);
  assign wr_ok    = wr_en_i && !wr_zero;

  // A register being freed by this cycle's write may be re-reserved immediately.
  assign rsv_ready_o = rsv_zero || !busy_q[rsv_addr_i] ||
                       (wr_en_i && (wr_addr_i == rsv_addr_i));
  assign rsv_ok      = rsv_en_i && rsv_ready_o && !rsv_zero;

  // Clear first so a same-cycle reservation of the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero_hit;
    logic          byp_hit;

    assign addr     = rd_addr_i[k*AW +: AW];
    assign zero_hit = ZERO_REG && (addr == '0);
    assign byp_hit  = BYPASS && wr_ok && (wr_addr_i == addr);

    assign rd_data_o[k*XLEN +: XLEN] = zero_hit ? '0 :
                                       byp_hit  ? wr_data_i : mem_q[addr];
    assign rd_busy_o[k] = !zero_hit && !byp_hit && busy_q[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb (bypass and non-bypass builds) plus a randomised
// 16x64, 3-port sweep against a reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the default (a) and BYPASS=0 (b) builds.
  logic [9:0]  rd_addr;
  logic        wr_en, rsv_en;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [63:0] data_a, data_b;
  logic [1:0]  busy_a, busy_b;
  logic        ready_a, ready_b;

  // Sweep build.
  logic [11:0]  s_rd_addr;
  logic [191:0] s_rd_data;
  logic [2:0]   s_busy;
  logic         s_wr_en, s_rsv_en, s_ready;
  logic [3:0]   s_wr_addr, s_rsv_addr;
  logic [63:0]  s_wr_data;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(data_a), .rd_busy_o(busy_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_a)
  );

  regfile_sb #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(data_b), .rd_busy_o(busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_b)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_s (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data),
    .rd_busy_o(s_busy), .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
    .rsv_en_i(s_rsv_en), .rsv_addr_i(s_rsv_addr), .rsv_ready_o(s_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd_addr = {5'd6, 5'd5};
    rsv_addr = 5'd6;
    #3;
    checks++; if (data_a !== 64'h0 || busy_a !== 2'b00 || ready_a !== 1'b1) begin
      errors++; $display("FAIL reset_a: data=%h busy=%b ready=%b, want 0/00/1", data_a, busy_a, ready_a);
    end
    checks++; if (s_rd_data !== 192'h0 || s_busy !== 3'b000 || s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s: data=%h busy=%b ready=%b", s_rd_data, s_busy, s_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1;
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    checks++; if (data_a[31:0] !== 32'hDEADBEEF || busy_a[1] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_a: x5=%h x6busy=%b, want deadbeef/1", data_a[31:0], busy_a[1]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (data_a[31:0] !== 32'h0 || busy_a !== 2'b00 || ready_a !== 1'b1) begin
      errors++; $display("FAIL async_reset_a: x5=%h busy=%b ready=%b", data_a[31:0], busy_a, ready_a);
    end
    checks++; if (data_b[31:0] !== 32'h0 || busy_b !== 2'b00) begin
      errors++; $display("FAIL async_reset_b: x5=%h busy=%b, want 0/00", data_b[31:0], busy_b);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    tick();
    rd_addr = {5'd0, 5'd7};
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    #1;
    checks++; if (data_a[31:0] !== 32'h12345678 || busy_a[0] !== 1'b0) begin
      errors++; $display("FAIL bypass_a: got %h busy %b, want 12345678/0", data_a[31:0], busy_a[0]);
    end
    checks++; if (data_b[31:0] !== 32'h0) begin
      errors++; $display("FAIL nobypass_b: got %h, want 00000000", data_b[31:0]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++; if (data_b[31:0] !== 32'h12345678 || data_a[31:0] !== 32'h12345678) begin
      errors++; $display("FAIL write_commit: a=%h b=%h, want 12345678", data_a[31:0], data_b[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd3, 5'd3};
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    checks++; if (ready_a !== 1'b1 || busy_a[1] !== 1'b0) begin
      errors++; $display("FAIL rsv_before: ready=%b busy=%b, want 1/0", ready_a, busy_a[1]);
    end
    tick();
    rsv_en = 1'b0;
    #1;
    checks++; if (busy_a[1] !== 1'b1 || busy_b[1] !== 1'b1 || ready_a !== 1'b0) begin
      errors++; $display("FAIL rsv_after: busy a=%b b=%b ready=%b, want 1/1/0",
                         busy_a[1], busy_b[1], ready_a);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    #1;
    checks++; if (ready_a !== 1'b1 || busy_a[0] !== 1'b0 || data_a[31:0] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wb_bypass_a: ready=%b busy=%b data=%h, want 1/0/a5a5a5a5",
                         ready_a, busy_a[0], data_a[31:0]);
    end
    checks++; if (busy_b[0] !== 1'b1 || data_b[31:0] !== 32'h0) begin
      errors++; $display("FAIL wb_nobypass_b: busy=%b data=%h, want 1/0", busy_b[0], data_b[31:0]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++; if (busy_a[1] !== 1'b0 || data_a[63:32] !== 32'hA5A5A5A5 ||
                  busy_b[1] !== 1'b0 || data_b[63:32] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wb_after: a=%h/%b b=%h/%b, want a5a5a5a5/0",
                         data_a[63:32], busy_a[1], data_b[63:32], busy_b[1]);
    end
  endtask

  task automatic test_same_cycle();
    rd_addr = {5'd9, 5'd9};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    #1;
    checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      errors++; $display("FAIL same_ready: a=%b b=%b, want 1", ready_a, ready_b);
    end
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    checks++; if (data_a[31:0] !== 32'h1 || busy_a !== 2'b11 || busy_b !== 2'b11 || ready_a !== 1'b0)
    begin
      errors++; $display("FAIL same_after: data=%h busy a=%b b=%b ready=%b, want 1/11/11/0",
                         data_a[31:0], busy_a, busy_b, ready_a);
    end
  endtask

  task automatic test_zero();
    rd_addr = 10'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    checks++; if (data_a !== 64'h0 || busy_a !== 2'b00 || ready_a !== 1'b1) begin
      errors++; $display("FAIL zero_same: data=%h busy=%b ready=%b, want 0/00/1", data_a, busy_a, ready_a);
    end
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    checks++; if (data_a !== 64'h0 || busy_a !== 2'b00 || ready_a !== 1'b1 ||
                  data_b !== 64'h0 || busy_b !== 2'b00) begin
      errors++; $display("FAIL zero_after: a=%h/%b/%b b=%h/%b, want zero, not busy, ready",
                         data_a, busy_a, ready_a, data_b, busy_b);
    end
  endtask

  task automatic test_sweep();
    logic [63:0] m [16];
    logic [15:0] b;
    logic [63:0] exp_d;
    logic        exp_b, exp_r;
    logic [3:0]  a;
    for (int i = 0; i < 16; i++) m[i] = 64'h0;
    b = '0;
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m[i] = 64'h0;
        b = '0;
      end
      s_wr_en    = ($urandom_range(0, 2) != 0);
      s_wr_addr  = 4'($urandom_range(0, 15));
      s_wr_data  = {$urandom, $urandom};
      s_rsv_en   = 1'($urandom_range(0, 1));
      s_rsv_addr = 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) s_rd_addr[k*4 +: 4] = 4'($urandom_range(0, 15));
      if (c % 4 == 0) s_rd_addr[8 +: 4] = s_rd_addr[0 +: 4];
      #1;
      for (int k = 0; k < 3; k++) begin
        a = s_rd_addr[k*4 +: 4];
        if (s_wr_en && s_wr_addr == a) begin
          exp_d = s_wr_data; exp_b = 1'b0;
        end else begin
          exp_d = m[a]; exp_b = b[a];
        end
        checks++; if (s_rd_data[k*64 +: 64] !== exp_d || s_busy[k] !== exp_b) begin
          errors++; $display("FAIL sweep_rd c=%0d port=%0d addr=%0d: got %h/%b want %h/%b",
                             c, k, a, s_rd_data[k*64 +: 64], s_busy[k], exp_d, exp_b);
        end
      end
      exp_r = !b[s_rsv_addr] || (s_wr_en && s_wr_addr == s_rsv_addr);
      checks++; if (s_ready !== exp_r) begin
        errors++; $display("FAIL sweep_ready c=%0d: got %b want %b", c, s_ready, exp_r);
      end
      tick();
      if (s_wr_en) begin
        m[s_wr_addr] = s_wr_data;
        b[s_wr_addr] = 1'b0;
      end
      if (s_rsv_en && exp_r) b[s_rsv_addr] = 1'b1;
    end
    s_wr_en = 1'b0; s_rsv_en = 1'b0;
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rsv_en = 1'b0; s_rsv_addr = '0;
    s_rd_addr = '0;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_same_cycle();
    test_zero();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a per-register busy scoreboard, for the riscv-soc core pipeline. It is the next-generation register file: width, depth and read-port count are parameters, writes commit on the clock edge, and the write-to-read bypass is optional. Decode uses the scoreboard to reserve a destination register at issue and to detect RAW hazards; writeback clears the reservation when it writes the result.

## Interface
- `XLEN`, default 32: register data width.
- `NREGS`, default 32: number of registers; must be a power of two and at least 2. `AW = $clog2(NREGS)`.
- `NRD`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: when 1, a same-cycle write is visible on the read ports; when 0, reads return pre-edge contents.
- `ZERO_REG`, default 1: when 1, register 0 is hardwired to zero.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rd_addr_i` in NRD*AW: read addresses; port k uses bits [k*AW +: AW].
- `rd_data_o` out NRD*XLEN: read data; port k uses bits [k*XLEN +: XLEN].
- `rd_busy_o` out NRD: port k's addressed register has a pending write.
- `wr_en_i` in 1: write enable.
- `wr_addr_i` in AW: write address.
- `wr_data_i` in XLEN: write data.
- `rsv_en_i` in 1: reserve a destination register (set its busy bit).
- `rsv_addr_i` in AW: register to reserve.
- `rsv_ready_o` out 1: a reservation of `rsv_addr_i` can be accepted this cycle.

## Operation
- **State:** `NREGS` x `XLEN` data array and `NREGS` busy bits.
- **Reset:** all data words and all busy bits are cleared asynchronously.
- **Write:** when `wr_en_i` is high at the edge, `wr_data_i` is stored in `wr_addr_i` and that register's busy bit is cleared.
- **Reservation:** accepted when `rsv_en_i` and `rsv_ready_o` are both high; the busy bit of `rsv_addr_i` is set at the edge.
  - `rsv_en_i` while `rsv_ready_o` is low has no effect. Upstream must stall.
- **rsv_ready_o** = `!busy[rsv_addr_i] || (wr_en_i && wr_addr_i == rsv_addr_i)`. A register being freed this cycle may be re-reserved in the same cycle.
- **Write and reservation to the same address in one cycle:** data is written and the busy bit ends at 1 (set wins over clear).
- **Read port k (combinational):**
  - With `BYPASS` = 1 and `wr_en_i` high with `wr_addr_i == rd_addr[k]`: `rd_data = wr_data_i` and `rd_busy = 0`.
  - Otherwise: `rd_data = array[rd_addr[k]]` and `rd_busy = busy[rd_addr[k]]`.
  - Multiple ports may address the same register; each returns identical values.
- **ZERO_REG = 1:**
  - Writes to register 0 are dropped, and so is their bypass.
  - Reservations of register 0 are dropped, and `rsv_ready_o` is 1 for address 0.
  - Reads of register 0 return 0 with busy 0.
- **ZERO_REG = 0:** register 0 behaves like every other register.
- **Writes to a non-busy register** are legal: data updates and busy stays 0.

## Timing
- Read latency is combinational (0 cycles); write latency is 1 edge.
- With `BYPASS` = 0, a written value appears on the read ports in the cycle after the edge.
- A reservation appears on `rd_busy_o` in the cycle after the edge.
- Reset is asynchronous: outputs change without waiting for `clk`.
  - During and after reset: every `rd_data_o` = 0, every `rd_busy_o` = 0, `rsv_ready_o` = 1.
- Reset asserted mid-operation discards all pending reservations and data.
- On the first edge after `rst_n` rises, writes and reservations are honoured normally.
- No combinational path from `rsv_en_i` to any output.

## Test plan
- **Reset:** write 0xDEADBEEF to x5, then assert `rst_n`=0 mid-cycle -> read x5 = 0 and busy = 0 immediately, without waiting for a clock edge.
- **Write/read with bypass:**
  - With `BYPASS` = 1: write 0x12345678 to x7 while port 0 reads x7 -> port 0 shows 0x12345678 in the same cycle.
  - With `BYPASS` = 0: the same stimulus shows 0 that cycle and 0x12345678 the next.
- **Scoreboard:**
  - Reserve x3 -> next cycle `rd_busy`[1] = 1 for x3 and `rsv_ready_o` = 0 for x3.
  - Write 0xA5A5A5A5 to x3 -> `rd_busy`=0 after the edge and data = 0xA5A5A5A5.
- **Simultaneous write and reservation:** x9 is busy; in one cycle, write 0x1 to x9 and reserve x9 -> `rsv_ready_o` = 1 that cycle; after the edge x9 = 0x1 and busy = 1.
- **Zero register (ZERO_REG = 1):** write 0xFFFFFFFF to x0 and reserve x0 -> all ports read x0 as 0 with busy 0; `rsv_ready_o` = 1.
- **Parameter sweep:** `NREGS`=16, `NRD`=3, `XLEN`=64, random writes and reads on all ports over 10k cycles -> output matches a reference model every cycle, including duplicate read addresses.
